// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the Mandelbrot pixel path: raster size,
// counter widths, FIFO entry layout and the optional output palette.
package mandelbrot_pkg;

  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  localparam int ENTRY_W   = 10;
  localparam int ENTRY_SOF = 9;
  localparam int ENTRY_EOL = 8;

  // Field order matches the bit layout: sof at bit 9, eol at bit 8, data below.
  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } pix_entry_t;

  // Escape-time gradient; the saturated count (never escaped) maps to black.
  localparam logic [3:0] PIXOUT_PALETTE [16] = '{
    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0
  };

endpackage

// File: rtl/pixout_fifo.sv
// Generic synchronous FIFO; pointers carry one extra MSB so full and empty
// are distinguishable. A push into a full FIFO is accepted only alongside a pop.
module pixout_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // NOTE: non-blocking assignments for every flop so all state updates see
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity and
  // the read mux forces zero when empty, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mandelbrot_pixel_out.sv
// Raster tracker, nibble packer and output FIFO behind a valid/ready port.
// Optional palette remap enabled by defining MANDEL_PIXOUT_PALETTE_EN.
module mandelbrot_pixel_out
  import mandelbrot_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1,
  parameter int IMG_W      = IMG_WIDTH,
  parameter int IMG_H      = IMG_HEIGHT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [3:0]         pix_data,
  input  logic               frame_start,
  input  logic               clear_ovf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_sof,
  output logic               out_eol,
  output logic               overflow,
  output logic [LEVEL_W-1:0] level,
  output logic               frame_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [3:0]         r_pending;
  logic               r_overflow;
  logic               r_frame_done;

  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic [3:0]         w_nib;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_rdata;
  pix_entry_t         w_wentry;
  pix_entry_t         w_head;

`ifdef MANDEL_PIXOUT_PALETTE_EN
  assign w_nib = PIXOUT_PALETTE[pix_data];
`else
  assign w_nib = pix_data;
`endif

  // A frame_start in the same cycle as a strobe places that pixel at the origin.
  assign w_x = frame_start ? '0 : r_x;
  assign w_y = frame_start ? '0 : r_y;

  assign w_push = pix_valid & w_x[0];
  assign w_pop  = out_ready & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  assign w_wentry.sof  = (w_x == X_W'(1)) && (w_y == '0);
  assign w_wentry.eol  = (w_x == X_LAST);
  assign w_wentry.data = {w_nib, r_pending};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_pending    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (pix_valid) begin
        if (!w_x[0]) r_pending <= w_nib;
        if (w_x == X_LAST) begin
          r_x <= '0;
          if (w_y == Y_LAST) begin
            r_y          <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_y <= w_y + 1'b1;
          end
        end else begin
          r_x <= w_x + 1'b1;
          r_y <= w_y;
        end
      end else if (frame_start) begin
        r_x       <= '0;
        r_y       <= '0;
        r_pending <= '0;
      end
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (reset)          r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (clear_ovf) r_overflow <= 1'b0;
  end

  pixout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (out_ready),
    .i_wdata (w_wentry),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_head     = w_rdata;
  assign out_valid  = ~w_empty;
  assign out_data   = w_head.data;
  assign out_sof    = w_head.sof;
  assign out_eol    = w_head.eol;
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mandelbrot_pixel_out.sv
// Self-checking bench: queue-based raster/FIFO model compared every cycle,
// plus directed literal checks; a small-raster instance covers frame wrap.
module tb_mandelbrot_pixel_out;

  localparam int DEPTH = 8;
  localparam int W     = 640;
  localparam int H     = 480;
  localparam int SW    = 8;
  localparam int SH    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [3:0] pix_data = '0;
  logic       frame_start = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_sof, out_eol, overflow, frame_done;
  logic [7:0] out_data;
  logic [3:0] level;

  logic       s_reset = 1'b1;
  logic       s_pix_valid = 1'b0;
  logic [3:0] s_pix_data = '0;
  logic       s_frame_start = 1'b0;
  logic       s_clear_ovf = 1'b0;
  logic       s_out_ready = 1'b1;
  logic       s_out_valid, s_out_sof, s_out_eol, s_overflow, s_frame_done;
  logic [7:0] s_out_data;
  logic [2:0] s_level;

  always #5 clk = ~clk;

  mandelbrot_pixel_out #(.FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .frame_start(frame_start), .clear_ovf(clear_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .overflow(overflow), .level(level), .frame_done(frame_done)
  );

  mandelbrot_pixel_out #(.FIFO_DEPTH(4), .IMG_W(SW), .IMG_H(SH)) u_dut_small (
    .clk(clk), .reset(s_reset), .pix_valid(s_pix_valid), .pix_data(s_pix_data),
    .frame_start(s_frame_start), .clear_ovf(s_clear_ovf), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_sof(s_out_sof),
    .out_eol(s_out_eol), .overflow(s_overflow), .level(s_level),
    .frame_done(s_frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] remap(input logic [3:0] n);
`ifdef MANDEL_PIXOUT_PALETTE_EN
    return mandelbrot_pkg::PIXOUT_PALETTE[n];
`else
    return n;
`endif
  endfunction

  // Behavioural model: integer raster position and a queue of expected bytes.
  logic [9:0] mq[$];
  int         mx, my;
  logic [3:0] mpend;
  logic       movf, mfd;
  bit         m_pop, m_push, m_drop;
  logic [9:0] m_e;
  bit         chk_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mx = 0; my = 0; mpend = '0; movf = 1'b0; mfd = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = 0;
      m_drop = 0;
      mfd    = 1'b0;
      if (frame_start) begin mx = 0; my = 0; mpend = '0; end
      if (pix_valid) begin
        if (mx % 2 == 0) mpend = remap(pix_data);
        else begin
          m_e = {(mx == 1 && my == 0), (mx == W - 1), remap(pix_data), mpend};
          if (mq.size() == DEPTH && !m_pop) m_drop = 1;
          else m_push = 1;
        end
        mx++;
        if (mx == W) begin
          mx = 0; my++;
          if (my == H) begin my = 0; mfd = 1'b1; end
        end
      end
      if (m_drop) movf = 1'b1;
      else if (clear_ovf) movf = 1'b0;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_e);
    end
  end

  logic [9:0] c_head;
  always @(negedge clk) begin
    if (chk_en) begin
      c_head = (mq.size() != 0) ? mq[0] : 10'h0;
      check("out_valid", out_valid, mq.size() != 0);
      check("level", level, mq.size());
      check("out_data", out_data, c_head[7:0]);
      check("out_sof", out_sof, c_head[9]);
      check("out_eol", out_eol, c_head[8]);
      check("overflow", overflow, movf);
      check("frame_done", frame_done, mfd);
    end
  end

  // Capture of consumed bytes for literal checks against hand-derived values.
  logic [9:0] got[$];
  logic [9:0] s_got[$];
  int         cyc = 0;
  int         s_fd_cnt = 0;
  int         s_fd_cyc = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back({out_sof, out_eol, out_data});
    if (s_out_valid && s_out_ready) s_got.push_back({s_out_sof, s_out_eol, s_out_data});
    if (s_frame_done) begin s_fd_cnt++; s_fd_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    pix_valid = 1'b0; frame_start = 1'b0; clear_ovf = 1'b0;
    s_pix_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    pix_valid = 1'b1; pix_data = d;
    tick();
  endtask

  task automatic s_send(input logic [3:0] d);
    s_pix_valid = 1'b1; s_pix_data = d;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (level != 0 && n < 2000) begin tick(); n++; end
    check("drain_done", (level == 0), 1);
  endtask

  int eol_cnt;
  int s_last_cyc;

  initial begin
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    s_reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);

    // 1: first byte, one-cycle latency
    do_reset();
    out_ready = 1'b1;
    send(4'h3);
    send(4'hA);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, {remap(4'hA), remap(4'h3)});
    check("t1_sof", out_sof, 1);
    check("t1_eol", out_eol, 0);
    drain();

    // 2: one full line, then first byte of line 1
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < W; i++) send(4'(i));
    drain();
    send(4'h0);
    send(4'h1);
    drain();
    check("t2_bytes", got.size(), 321);
    check("t2_first", got[0], {2'b10, remap(4'h1), remap(4'h0)});
    check("t2_last", got[319], {2'b01, remap(4'hF), remap(4'hE)});
    eol_cnt = 0;
    for (int i = 0; i < 320; i++) if (got[i][8]) eol_cnt++;
    check("t2_eol_count", eol_cnt, 1);
    check("t2_line1_sof", got[320][9], 0);

    // 3: overflow with consumer stalled, set-beats-clear, drain order
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send(4'(k));
      send(4'(15 - k));
    end
    check("t3_level", level, 8);
    check("t3_ovf", overflow, 1);
    send(4'h0);
    clear_ovf = 1'b1;
    send(4'h1);
    check("t3_set_wins", overflow, 1);
    got.delete();
    drain();
    check("t3_drained", got.size(), 8);
    check("t3_head", got[0][7:0], {remap(4'hF), remap(4'h0)});
    check("t3_tail", got[7][7:0], {remap(4'h8), remap(4'h7)});
    clear_ovf = 1'b1;
    tick();
    check("t3_cleared", overflow, 0);

    // 4: simultaneous push and pop while full
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(4'(k));
      send(4'(k));
    end
    check("t4_full", level, 8);
    send(4'hC);
    got.delete();
    out_ready = 1'b1;
    send(4'hD);
    check("t4_level", level, 8);
    check("t4_no_ovf", overflow, 0);
    drain();
    check("t4_count", got.size(), 9);
    check("t4_first", got[0][7:0], {remap(4'h0), remap(4'h0)});
    check("t4_new_last", got[8][7:0], {remap(4'hD), remap(4'hC)});

    // 5: frame wrap on the small-raster instance
    s_got.delete();
    for (int i = 0; i < SW * SH; i++) s_send(4'(i));
    s_last_cyc = cyc;
    s_send(4'h4);
    s_send(4'h5);
    repeat (4) tick();
    check("t5_fd_count", s_fd_cnt, 1);
    check("t5_fd_timing", s_fd_cyc, s_last_cyc);
    check("t5_bytes", s_got.size(), 13);
    check("t5_first_sof", s_got[0][9], 1);
    check("t5_line_eol", s_got[3], {2'b01, remap(4'h7), remap(4'h6)});
    check("t5_last_byte", s_got[11], {2'b01, remap(4'h7), remap(4'h6)});
    check("t5_next_frame", s_got[12], {2'b10, remap(4'h5), remap(4'h4)});

    // 6: frame_start discards pending nibble; same-cycle start; reset mid-drain
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3 * W + 5; i++) send(4'(i));
    drain();
    out_ready = 1'b0;
    frame_start = 1'b1;
    tick();
    send(4'h1);
    send(4'h2);
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, {remap(4'h2), remap(4'h1)});
    check("t6_sof", out_sof, 1);
    send(4'h3);
    frame_start = 1'b1;
    send(4'h7);
    send(4'h8);
    check("t6_level", level, 2);
    send(4'h9);
    send(4'h9);
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_level", level, 0);
    send(4'h5);
    send(4'h6);
    check("t6_after_rst", {out_sof, out_data}, {1'b1, remap(4'h6), remap(4'h5)});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
